// File: rtl/cmp_meter_pkg.sv
// Shared types and constants for the approximate-comparator error meter.
package cmp_meter_pkg;

    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

    localparam int MAX_W = 16;
    localparam logic [2*MAX_W-1:0] NO_ERR_IDX = '1;

    // The error counter has to reach 2^(2W) inclusive, so it needs one bit more than the index.
    function automatic int cnt_width(input int w);
        return 2 * w + 1;
    endfunction

endpackage

// File: rtl/cmp_error_meter_if.sv
// Operand/response bus between the error meter (master) and the comparator under test (slave).
interface cmp_error_meter_if #(
    parameter int W = 3
);
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         op_valid;
    logic         dut_out;

    modport master (output op_a, output op_b, output op_valid, input dut_out);
    modport slave  (input op_a, input op_b, input op_valid, output dut_out);
endinterface

// File: rtl/cmp_meter_delay.sv
// LAT-stage shift register that aligns {valid, exp, idx} with the comparator response.
module cmp_meter_delay #(
    parameter int LAT = 0,
    parameter int DW  = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    generate
        if (LAT == 0) begin : g_pass
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign dout = din;
        end else begin : g_pipe
            logic [DW-1:0] stage [LAT];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < LAT; i++) stage[i] <= '0;
                end else begin
                    stage[0] <= din;
                    for (int i = 1; i < LAT; i++) stage[i] <= stage[i-1];
                end
            end

            assign dout = stage[LAT-1];
        end
    endgenerate

endmodule

// File: rtl/cmp_error_meter.sv
// Exhaustive sweep and mismatch scoring for W-bit approximate "a > b" comparators.
// Optional macro CMP_ERR_SPLIT_EN adds separate false-positive / false-negative counters.
module cmp_error_meter
    import cmp_meter_pkg::*;
#(
    parameter int W       = 3,
    parameter int DUT_LAT = 0,
    parameter int CNT_W   = cnt_width(W)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    cmp_error_meter_if.master   cmp,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    err_count,
    output logic [2*W-1:0]      first_err_idx
`ifdef CMP_ERR_SPLIT_EN
    ,
    output logic [CNT_W-1:0]    fp_count,
    output logic [CNT_W-1:0]    fn_count
`endif
);

    localparam int IW      = 2 * W;
    localparam int PW      = IW + 2;
    localparam int DRAIN_W = (DUT_LAT > 1) ? $clog2(DUT_LAT) : 1;

    localparam logic [IW-1:0]      LAST_IDX   = '1;
    localparam logic [IW-1:0]      NO_ERR     = NO_ERR_IDX[IW-1:0];
    localparam logic [CNT_W-1:0]   ERR_SAT    = CNT_W'(64'd1 << IW);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'((DUT_LAT > 0) ? DUT_LAT - 1 : 0);

    state_t               state, state_nxt;
    logic [IW-1:0]        idx;
    logic [DRAIN_W-1:0]   drain_cnt;
    logic                 start_ok;
    logic                 exp_now;
    logic                 mismatch;
    logic [PW-1:0]        pipe_in, pipe_out;
    logic                 d_valid, d_exp;
    logic [IW-1:0]        d_idx;

    assign start_ok = start && ((state == IDLE) || (state == DONE));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = SWEEP;
            SWEEP:      if (idx == LAST_IDX) state_nxt = (DUT_LAT == 0) ? DONE : DRAIN;
            DRAIN:      if (drain_cnt == DRAIN_LAST) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cmp.op_valid = (state == SWEEP);
        busy         = (state == SWEEP) || (state == DRAIN);
        done         = (state == DONE);
    end

    // idx parks on the terminal point, so the operands hold through DRAIN and DONE.
    assign cmp.op_a = idx[IW-1:W];
    assign cmp.op_b = idx[W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= '0;
            drain_cnt <= '0;
        end else begin
            if (start_ok)
                idx <= '0;
            else if ((state == SWEEP) && (idx != LAST_IDX))
                idx <= idx + 1'b1;
            drain_cnt <= (state == DRAIN) ? drain_cnt + 1'b1 : '0;
        end
    end

    assign exp_now = cmp.op_a > cmp.op_b;
    assign pipe_in = {cmp.op_valid, exp_now, idx};

    cmp_meter_delay #(
        .LAT (DUT_LAT),
        .DW  (PW)
    ) u_delay (
        .clk  (clk),
        .rst  (rst),
        .din  (pipe_in),
        .dout (pipe_out)
    );

    assign {d_valid, d_exp, d_idx} = pipe_out;
    assign mismatch = d_valid && (cmp.dut_out != d_exp);

    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            err_count     <= '0;
            first_err_idx <= NO_ERR;
`ifdef CMP_ERR_SPLIT_EN
            fp_count      <= '0;
            fn_count      <= '0;
`endif
        end else if (mismatch) begin
            if (err_count != ERR_SAT) err_count <= err_count + 1'b1;
            if (first_err_idx == NO_ERR) first_err_idx <= d_idx;
`ifdef CMP_ERR_SPLIT_EN
            if (d_exp) fn_count <= fn_count + 1'b1;
            else       fp_count <= fp_count + 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_cmp_error_meter.sv
// Scoreboard bench for cmp_error_meter: one combinational and one two-cycle-latency comparator.
`timescale 1ns/1ps
module tb_cmp_error_meter;
    import cmp_meter_pkg::*;

    localparam int W       = 3;
    localparam int CNT_W   = cnt_width(W);
    localparam int M_EXACT = 0;
    localparam int M_STUCK = 1;
    localparam int M_GE    = 2;
    localparam int M_INV   = 3;

    typedef struct {
        int err;
        int first;
        int fp;
        int fn;
        int busy_cycles;
        int done_cyc;
    } exp_t;

    exp_t sb0[$];
    exp_t sb2[$];

    logic clk = 1'b0;
    logic rst;
    logic start0, start2;
    int   mode0, mode2;
    int   cyc = 0;
    int   n_compared = 0;
    int   n_mismatched = 0;

    logic             busy0, done0, busy2, done2;
    logic [CNT_W-1:0] err0, err2;
    logic [2*W-1:0]   first0, first2;
`ifdef CMP_ERR_SPLIT_EN
    logic [CNT_W-1:0] fp0, fn0, fp2, fn2;
`endif

    cmp_error_meter_if #(.W(W)) bus0 ();
    cmp_error_meter_if #(.W(W)) bus2 ();

    cmp_error_meter #(.W(W), .DUT_LAT(0)) u_lat0 (
        .clk           (clk),
        .rst           (rst),
        .start         (start0),
        .cmp           (bus0),
        .busy          (busy0),
        .done          (done0),
        .err_count     (err0),
        .first_err_idx (first0)
`ifdef CMP_ERR_SPLIT_EN
        ,
        .fp_count      (fp0),
        .fn_count      (fn0)
`endif
    );

    cmp_error_meter #(.W(W), .DUT_LAT(2)) u_lat2 (
        .clk           (clk),
        .rst           (rst),
        .start         (start2),
        .cmp           (bus2),
        .busy          (busy2),
        .done          (done2),
        .err_count     (err2),
        .first_err_idx (first2)
`ifdef CMP_ERR_SPLIT_EN
        ,
        .fp_count      (fp2),
        .fn_count      (fn2)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Comparator variants standing in for library candidates.
    function automatic logic cmpModel(input int mode, input logic [W-1:0] a, input logic [W-1:0] b);
        case (mode)
            M_EXACT: return a > b;
            M_STUCK: return 1'b0;
            M_GE:    return a >= b;
            default: return !(a > b);
        endcase
    endfunction

    logic r1, r2;
    always_comb bus0.dut_out = cmpModel(mode0, bus0.op_a, bus0.op_b);
    always @(posedge clk) begin
        r1 <= cmpModel(mode2, bus2.op_a, bus2.op_b);
        r2 <= r1;
    end
    assign bus2.dut_out = r2;

    task automatic compareValue(input string name, input int act, input int expv);
        n_compared++;
        if (act != expv) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    task automatic sampleOutputs(input int inst, output int busy, output int done, output int err,
                                 output int first, output int valid, output int a, output int b);
        if (inst == 0) begin
            busy = int'(busy0); done = int'(done0); err = int'(err0); first = int'(first0);
            valid = int'(bus0.op_valid); a = int'(bus0.op_a); b = int'(bus0.op_b);
        end else begin
            busy = int'(busy2); done = int'(done2); err = int'(err2); first = int'(first2);
            valid = int'(bus2.op_valid); a = int'(bus2.op_a); b = int'(bus2.op_b);
        end
    endtask

    task automatic checkReset(input int inst);
        int bz, dn, er, fi, v, a, b;
        sampleOutputs(inst, bz, dn, er, fi, v, a, b);
        compareValue($sformatf("rst%0d_busy", inst), bz, 0);
        compareValue($sformatf("rst%0d_done", inst), dn, 0);
        compareValue($sformatf("rst%0d_err_count", inst), er, 0);
        compareValue($sformatf("rst%0d_first_err_idx", inst), fi, 63);
        compareValue($sformatf("rst%0d_op_valid", inst), v, 0);
        compareValue($sformatf("rst%0d_op_a", inst), a, 0);
        compareValue($sformatf("rst%0d_op_b", inst), b, 0);
    endtask

    // Pulses start and, when tracked, queues the sweep result the monitor should see.
    task automatic applyStimulus(input int inst, input int mode, input int err, input int first,
                                 input int fp, input int fn, input bit track, output int es);
        exp_t e;
        int lat, bz, dn, er, fi, v, a, b;
        lat = (inst == 0) ? 0 : 2;
        if (inst == 0) mode0 = mode; else mode2 = mode;
        @(negedge clk);
        if (inst == 0) start0 = 1'b1; else start2 = 1'b1;
        @(posedge clk);
        #1;
        if (inst == 0) start0 = 1'b0; else start2 = 1'b0;
        es = cyc;
        if (track) begin
            e = '{err, first, fp, fn, 64 + lat, es + 64 + lat};
            if (inst == 0) sb0.push_back(e); else sb2.push_back(e);
        end
        sampleOutputs(inst, bz, dn, er, fi, v, a, b);
        compareValue($sformatf("start%0d_done", inst), dn, 0);
        compareValue($sformatf("start%0d_err_count", inst), er, 0);
        compareValue($sformatf("start%0d_first_err_idx", inst), fi, 63);
        compareValue($sformatf("start%0d_busy", inst), bz, 1);
        compareValue($sformatf("start%0d_op_valid", inst), v, 1);
        compareValue($sformatf("start%0d_op_ab", inst), a * 8 + b, 0);
    endtask

    task automatic pulseStart(input int inst);
        @(negedge clk);
        if (inst == 0) start0 = 1'b1; else start2 = 1'b1;
        @(posedge clk);
        #1;
        if (inst == 0) start0 = 1'b0; else start2 = 1'b0;
    endtask

    task automatic waitCycle(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic waitDone(input int inst);
        int n = 0;
        while (((inst == 0) ? sb0.size() : sb2.size()) != 0 && n < 400) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (((inst == 0) ? sb0.size() : sb2.size()) != 0) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL done_timeout%0d: got no done within %0d cycles, expected done", inst, n);
            if (inst == 0) sb0.delete(); else sb2.delete();
        end
    endtask

    task automatic checkOutput(input int inst, input int err, input int first, input int fp,
                               input int fn, input int busy_cycles);
        exp_t e;
        if (((inst == 0) ? sb0.size() : sb2.size()) == 0) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL unexpected_done%0d: got done at cycle %0d, expected none", inst, cyc);
            return;
        end
        e = (inst == 0) ? sb0.pop_front() : sb2.pop_front();
        compareValue($sformatf("sweep%0d_err_count", inst), err, e.err);
        compareValue($sformatf("sweep%0d_first_err_idx", inst), first, e.first);
        compareValue($sformatf("sweep%0d_busy_cycles", inst), busy_cycles, e.busy_cycles);
        compareValue($sformatf("sweep%0d_done_cycle", inst), cyc, e.done_cyc);
`ifdef CMP_ERR_SPLIT_EN
        compareValue($sformatf("sweep%0d_fp_count", inst), fp, e.fp);
        compareValue($sformatf("sweep%0d_fn_count", inst), fn, e.fn);
`else
        if (fp != 0 || fn != 0) compareValue($sformatf("sweep%0d_split_absent", inst), fp + fn, 0);
`endif
    endtask

    int  busy_cnt0 = 0, busy_cnt2 = 0;
    logic done_prev0 = 1'b0, done_prev2 = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            busy_cnt0 = 0; busy_cnt2 = 0;
            done_prev0 = 1'b0; done_prev2 = 1'b0;
        end else begin
            if (busy0) busy_cnt0++;
            if (busy2) busy_cnt2++;
            if (done0 && !done_prev0) begin
`ifdef CMP_ERR_SPLIT_EN
                checkOutput(0, int'(err0), int'(first0), int'(fp0), int'(fn0), busy_cnt0);
`else
                checkOutput(0, int'(err0), int'(first0), 0, 0, busy_cnt0);
`endif
                busy_cnt0 = 0;
            end
            if (done2 && !done_prev2) begin
`ifdef CMP_ERR_SPLIT_EN
                checkOutput(2, int'(err2), int'(first2), int'(fp2), int'(fn2), busy_cnt2);
`else
                checkOutput(2, int'(err2), int'(first2), 0, 0, busy_cnt2);
`endif
                busy_cnt2 = 0;
            end
            done_prev0 = done0;
            done_prev2 = done2;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion by 200000 ns, expected summary");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int es, bz, dn, er, fi, v, a, b;
        rst = 1'b1; start0 = 1'b0; start2 = 1'b0; mode0 = M_EXACT; mode2 = M_EXACT;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checkReset(0);
        checkReset(2);

        applyStimulus(0, M_EXACT, 0, 63, 0, 0, 1'b1, es);
        waitDone(0);
        applyStimulus(0, M_STUCK, 28, 8, 0, 28, 1'b1, es);
        waitDone(0);
        applyStimulus(0, M_INV, 64, 0, 36, 28, 1'b1, es);
        waitDone(0);
        applyStimulus(2, M_GE, 8, 0, 8, 0, 1'b1, es);
        waitDone(2);
        applyStimulus(2, M_EXACT, 0, 63, 0, 0, 1'b1, es);
        waitDone(2);

        // Abort a stuck-at-0 sweep after indices 0..28 have been scored.
        applyStimulus(0, M_STUCK, 0, 0, 0, 0, 1'b0, es);
        waitCycle(es + 29);
        sampleOutputs(0, bz, dn, er, fi, v, a, b);
        compareValue("abort_pre_err_count", er, 6);
        compareValue("abort_pre_first_err_idx", fi, 8);
        compareValue("abort_pre_busy", bz, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkReset(0);
        applyStimulus(0, M_STUCK, 28, 8, 0, 28, 1'b1, es);
        waitDone(0);

        // Starts during SWEEP and DRAIN must not disturb the running sweep.
        applyStimulus(2, M_GE, 8, 0, 8, 0, 1'b1, es);
        waitCycle(es + 10);
        pulseStart(2);
        waitCycle(es + 64);
        sampleOutputs(2, bz, dn, er, fi, v, a, b);
        compareValue("drain_busy", bz, 1);
        compareValue("drain_op_valid", v, 0);
        compareValue("drain_op_ab_held", a * 8 + b, 63);
        pulseStart(2);
        waitDone(2);
        applyStimulus(2, M_INV, 64, 0, 36, 28, 1'b1, es);
        waitDone(2);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
